// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter
//   Shares one spell_mem_dff-style memory between two requesters:
//   port 0 (core) and port 1 (loader/debug). A request is arbitrated in IDLE,
//   its payload is latched onto the mem_* bus, and select is held until the
//   memory reports data_ready (or the access times out). A one-cycle ack
//   (plus err and read data) is returned in RELEASE. RELEASE is also the
//   mandatory deselect cycle that lets the memory re-arm its latency counter.
//
// Parameters
//   FIXED_PRIO  0 = round-robin on ties, 1 = port 0 always wins ties
//   TIMEOUT     cycles in ACCESS without ready before an error ack (0 = never)
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   pN_req/addr/wdata/type/write   request N (0,1); held until pN_ack
//   pN_ack, pN_err          one-cycle completion pulse and its error flag
//   rdata                   read data in the ack cycle of a read, else 0
//   mem_select/addr/data_in/type/write   memory request bus (latched)
//   mem_data_out, mem_data_ready         memory response
//   busy                    arbiter not idle
//   timeout_flag            sticky, set by any timeout, cleared by reset
module spell_mem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p0_req,
    input  logic [7:0] p0_addr,
    input  logic [7:0] p0_wdata,
    input  logic [1:0] p0_type,
    input  logic       p0_write,
    output logic       p0_ack,
    output logic       p0_err,
    input  logic       p1_req,
    input  logic [7:0] p1_addr,
    input  logic [7:0] p1_wdata,
    input  logic [1:0] p1_type,
    input  logic       p1_write,
    output logic       p1_ack,
    output logic       p1_err,
    output logic [7:0] rdata,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic [1:0] mem_type,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       busy,
    output logic       timeout_flag
);

    // Memory type encodings understood by the memory; anything else is rejected.
    localparam logic [1:0] MEM_TYPE_DATA = 2'b00;
    localparam logic [1:0] MEM_TYPE_CODE = 2'b01;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_ERRACK  = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
    localparam logic       USE_FIXED   = (FIXED_PRIO != 0);
    localparam logic       USE_TIMEOUT = (TIMEOUT != 0);

    logic [1:0] state;
    logic       gnt;        // port owning the current transaction
    logic       last_gnt;   // port granted most recently (round-robin pointer)
    logic [7:0] timer;

    logic       grant_p1;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic [1:0] sel_type;
    logic       sel_write;
    logic       type_ok;
    logic       timed_out;

    // Tie-break: fixed priority picks port 0; round-robin picks the port not
    // granted last. last_gnt resets to 1 so port 0 wins the first tie.
    always_comb begin
        grant_p1 = p1_req;
        if (p0_req && p1_req)
            grant_p1 = USE_FIXED ? 1'b0 : ~last_gnt;
    end

    always_comb begin
        sel_addr  = grant_p1 ? p1_addr  : p0_addr;
        sel_wdata = grant_p1 ? p1_wdata : p0_wdata;
        sel_type  = grant_p1 ? p1_type  : p0_type;
        sel_write = grant_p1 ? p1_write : p0_write;
        type_ok   = (sel_type == MEM_TYPE_DATA) || (sel_type == MEM_TYPE_CODE);
        timed_out = USE_TIMEOUT && (timer == TIMEOUT_CNT);
    end

    assign mem_select = (state == ST_ACCESS);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            gnt          <= 1'b0;
            last_gnt     <= 1'b1;
            timer        <= 8'd0;
            p0_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p1_ack       <= 1'b0;
            p1_err       <= 1'b0;
            rdata        <= 8'd0;
            mem_addr     <= 8'd0;
            mem_data_in  <= 8'd0;
            mem_type     <= 2'd0;
            mem_write    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            // ack/err/rdata are single-cycle pulses; they are only set on the
            // transition into RELEASE.
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            rdata  <= 8'd0;
            case (state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        gnt         <= grant_p1;
                        mem_addr    <= sel_addr;
                        mem_data_in <= sel_wdata;
                        mem_type    <= sel_type;
                        mem_write   <= sel_write;
                        state       <= type_ok ? ST_ACCESS : ST_ERRACK;
                    end
                end
                ST_ACCESS: begin
                    if (timer != 8'hFF)
                        timer <= timer + 8'd1;
                    // Ready takes precedence over a timeout in the same cycle.
                    if (mem_data_ready) begin
                        p0_ack <= ~gnt;
                        p1_ack <= gnt;
                        rdata  <= mem_write ? 8'd0 : mem_data_out;
                        state  <= ST_RELEASE;
                    end else if (timed_out) begin
                        p0_ack       <= ~gnt;
                        p1_ack       <= gnt;
                        p0_err       <= ~gnt;
                        p1_err       <= gnt;
                        timeout_flag <= 1'b1;
                        state        <= ST_RELEASE;
                    end
                end
                ST_ERRACK: begin
                    // Bad type: the memory is never selected. The error ack is
                    // issued through RELEASE like every other completion, so the
                    // ack cycle always precedes IDLE and a requester dropping req
                    // after its ack is never mistaken for a new request.
                    p0_ack <= ~gnt;
                    p1_ack <= gnt;
                    p0_err <= ~gnt;
                    p1_err <= gnt;
                    state  <= ST_RELEASE;
                end
                default: begin // ST_RELEASE: deselect cycle
                    last_gnt <= gnt;
                    timer    <= 8'd0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb_spell_mem_arbiter
//   Two arbiter instances (g=0 round-robin, g=1 fixed priority), each with a
//   small behavioural memory: ready after 5 cycles of select, data bank split
//   by type bit 0, preloaded with addr^0x5A (data) / addr^0x96 (code) and
//   data[0x12]=0xA5. Expected acks are queued by the stimulus and consumed by a
//   monitor that watches the ack outputs.
module tb_spell_mem_arbiter;

    logic       clock;
    logic       rst;
    logic       req   [2][2];
    logic [7:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic [1:0] typ   [2][2];
    logic       wr    [2][2];
    logic       ack   [2][2];
    logic       err   [2][2];
    logic [7:0] rdata [2];
    logic       msel  [2];
    logic [7:0] maddr [2];
    logic [7:0] mdin  [2];
    logic [1:0] mtype [2];
    logic       mwrite[2];
    logic [7:0] mdout [2];
    logic       mready[2];
    logic       busy  [2];
    logic       tflag [2];

    logic [7:0] mem [2][512];
    logic [2:0] mcnt[2];
    logic       never_ready;
    int         cyc = 0;
    int         sel_cycles[2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         inst;
        int         port;
        logic       err;
        logic [7:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spell_mem_arbiter #(.FIXED_PRIO(g), .TIMEOUT(15)) u_dut (
            .clock(clock), .reset(rst),
            .p0_req(req[g][0]), .p0_addr(addr[g][0]), .p0_wdata(wdata[g][0]),
            .p0_type(typ[g][0]), .p0_write(wr[g][0]), .p0_ack(ack[g][0]), .p0_err(err[g][0]),
            .p1_req(req[g][1]), .p1_addr(addr[g][1]), .p1_wdata(wdata[g][1]),
            .p1_type(typ[g][1]), .p1_write(wr[g][1]), .p1_ack(ack[g][1]), .p1_err(err[g][1]),
            .rdata(rdata[g]), .mem_select(msel[g]), .mem_addr(maddr[g]),
            .mem_data_in(mdin[g]), .mem_type(mtype[g]), .mem_write(mwrite[g]),
            .mem_data_out(mdout[g]), .mem_data_ready(mready[g]),
            .busy(busy[g]), .timeout_flag(tflag[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model
    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (msel[g]) sel_cycles[g] <= sel_cycles[g] + 1;
            if (rst) begin
                mcnt[g] <= 3'd0;
                for (int i = 0; i < 512; i++)
                    mem[g][i] <= (i < 256) ? (8'(i) ^ 8'h5A) : (8'(i) ^ 8'h96);
                mem[g][18] <= 8'hA5;
            end else begin
                mcnt[g] <= !msel[g] ? 3'd0 : (mcnt[g] == 3'd7) ? mcnt[g] : mcnt[g] + 3'd1;
                if (mready[g] && mwrite[g]) mem[g][{mtype[g][0], maddr[g]}] <= mdin[g];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mready[g] = msel[g] && (mcnt[g] == 3'd4) && !never_ready;
            mdout[g]  = mem[g][{mtype[g][0], maddr[g]}];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int g, input int p, input logic e, input logic [7:0] d);
        exp_t x;
        x.inst = g; x.port = p; x.err = e; x.rdata = d;
        exp_q.push_back(x);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                if (ack[g][0] && ack[g][1]) begin
                    checks++; errors++;
                    $display("FAIL both_acks: inst %0d acked both ports (cycle %0d)", g, cyc);
                end else if (ack[g][0] || ack[g][1]) begin
                    int p;
                    p = ack[g][1] ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: inst %0d port %0d err %0b rdata %0h, nothing expected",
                                 g, p, err[g][p], rdata[g]);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        checks++;
                        if (x.inst != g || x.port != p || x.err !== err[g][p] || x.rdata !== rdata[g]) begin
                            errors++;
                            $display("FAIL ack_match: got inst %0d port %0d err %0b rdata %0h, expected inst %0d port %0d err %0b rdata %0h",
                                     g, p, err[g][p], rdata[g], x.inst, x.port, x.err, x.rdata);
                        end
                    end
                    chk("select_low_in_ack_cycle", 32'(msel[g]), 32'd0);
                end
            end
        end
    endtask

    // One requester transaction: raise req, wait (bounded) for ack, drop req.
    task automatic do_req(input int g, input int p, input logic [7:0] a, input logic [7:0] d,
                          input logic [1:0] t, input logic w, input int exp_lat);
        int t0;
        bit got;
        @(negedge clock);
        addr[g][p] = a; wdata[g][p] = d; typ[g][p] = t; wr[g][p] = w; req[g][p] = 1'b1;
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clock);
            if (ack[g][p]) got = 1'b1;
        end
        req[g][p] = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_wait: inst %0d port %0d got no ack within 200 cycles, ack required", g, p);
        end else if (exp_lat >= 0) begin
            chk($sformatf("latency_i%0d_p%0d", g, p), 32'(cyc - t0), 32'(exp_lat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, completion required");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst = 1'b1;
        never_ready = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++) begin
                req[g][p] = 0; addr[g][p] = 0; wdata[g][p] = 0; typ[g][p] = 0; wr[g][p] = 0;
            end
        fork monitor(); join_none

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_select", 32'(msel[0]), 0);
        chk("reset_busy",   32'(busy[0]), 0);
        chk("reset_tflag",  32'(tflag[0]), 0);
        chk("reset_acks",   32'({ack[0][0], ack[0][1], err[0][0], err[0][1]}), 0);
        chk("reset_rdata",  32'(rdata[0]), 0);
        chk("reset_maddr",  32'(maddr[0]), 0);
        rst = 1'b0;

        // 1: read of preloaded data
        push(0, 0, 1'b0, 8'hA5);
        do_req(0, 0, 8'h12, 8'h00, 2'b00, 1'b0, 6);

        // 2: write then read back, code bank
        push(0, 1, 1'b0, 8'h00);
        do_req(0, 1, 8'hFF, 8'h3C, 2'b01, 1'b1, 6);
        push(0, 1, 1'b0, 8'h3C);
        do_req(0, 1, 8'hFF, 8'h00, 2'b01, 1'b0, 6);

        // 3a: contention, round-robin -> 0,1,0,1
        push(0, 0, 1'b0, 8'h7A);
        push(0, 1, 1'b0, 8'h6A);
        push(0, 0, 1'b0, 8'h7B);
        push(0, 1, 1'b0, 8'h6B);
        fork
            begin do_req(0, 0, 8'h20, 0, 2'b00, 0, -1); do_req(0, 0, 8'h21, 0, 2'b00, 0, -1); end
            begin do_req(0, 1, 8'h30, 0, 2'b00, 0, -1); do_req(0, 1, 8'h31, 0, 2'b00, 0, -1); end
        join

        // 3b: fixed priority; port 0 was granted last yet still wins the tie
        push(1, 0, 1'b0, 8'h1A);
        do_req(1, 0, 8'h40, 0, 2'b00, 0, 6);
        push(1, 0, 1'b0, 8'h1B);
        push(1, 1, 1'b0, 8'h0A);
        fork
            do_req(1, 0, 8'h41, 0, 2'b00, 0, -1);
            do_req(1, 1, 8'h50, 0, 2'b00, 0, -1);
        join

        // 4: bad type -> error ack two cycles after req, memory never selected
        s0 = sel_cycles[0];
        push(0, 0, 1'b1, 8'h00);
        do_req(0, 0, 8'h12, 8'h00, 2'b11, 1'b0, 2);
        chk("badtype_no_select", 32'(sel_cycles[0] - s0), 0);

        // 5: timeout, then a normal read
        never_ready = 1'b1;
        push(0, 0, 1'b1, 8'h00);
        do_req(0, 0, 8'h12, 8'h00, 2'b00, 1'b0, 17);
        chk("timeout_flag_set", 32'(tflag[0]), 1);
        never_ready = 1'b0;
        push(0, 0, 1'b0, 8'hA5);
        do_req(0, 0, 8'h12, 8'h00, 2'b00, 1'b0, 6);
        chk("timeout_flag_sticky", 32'(tflag[0]), 1);

        // 6: reset mid-ACCESS
        @(negedge clock);
        addr[0][0] = 8'h13; typ[0][0] = 2'b00; wr[0][0] = 1'b0; req[0][0] = 1'b1;
        repeat (3) @(negedge clock);
        chk("midaccess_busy",   32'(busy[0]), 1);
        chk("midaccess_select", 32'(msel[0]), 1);
        rst = 1'b1;
        req[0][0] = 1'b0;
        #1;
        chk("reset_drops_select", 32'(msel[0]), 0);
        chk("reset_drops_busy",   32'(busy[0]), 0);
        chk("reset_no_ack",       32'({ack[0][0], ack[0][1]}), 0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        chk("reset_clears_tflag", 32'(tflag[0]), 0);
        push(0, 0, 1'b0, 8'h49);
        do_req(0, 0, 8'h13, 8'h00, 2'b00, 1'b0, 6);

        repeat (5) @(negedge clock);
        chk("all_expected_acks_seen", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
